ssm_word_dispatch: RTL and testbench
====================================

SSM_WORD_DISPATCH -- requirements
Module: ssm_word_dispatch

Interface
REQ-001 SHALL have parameter NUM_SSM, default 4, number of substream parsers served (1..8).
REQ-002 SHALL have parameter WORD_W, default 128, bitstream word width in bits.
REQ-003 SHALL have parameter DEPTH, default 8, word buffer depth; power of two, >= NUM_SSM.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_vld  input  1  upstream word valid.
REQ-007 SHALL have port in_data  input  WORD_W  upstream bitstream word.
REQ-008 SHALL have port in_rdy  output  1  buffer can accept one word this cycle.
REQ-009 SHALL have port flush  input  1  synchronous clear of buffered words (new slice).
REQ-010 SHALL have port ssm_rd_en  input  NUM_SSM  per-parser word request, bit i = SSM i.
REQ-011 SHALL have port ssm_rd_gnt  output  NUM_SSM  per-parser grant, word valid on ssm_data this cycle.
REQ-012 SHALL have port ssm_data  output  NUM_SSM*WORD_W  slice i = word for SSM i.
REQ-013 SHALL have port occupancy  output  $clog2(DEPTH+1)  buffered word count.

Function
REQ-014 SHALL push in_data into the circular buffer when in_vld & in_rdy; in_rdy = (occupancy < DEPTH), driven from registered state only.
REQ-015 SHALL compute req_n = popcount(ssm_rd_en) and grant all requests in the same cycle iff occupancy >= req_n (registered value, excluding this cycle's push); otherwise ssm_rd_gnt = 0 (all-or-nothing stall).
REQ-016 SHALL, on grant, give requesting SSMs consecutive buffered words in ascending SSM index: SSM i receives buffer[rd_ptr + popcount(ssm_rd_en[i-1:0])].
REQ-017 SHALL drive ssm_data slice i combinationally from the buffer (zero-cycle latency); slices for non-granted SSMs SHALL be 0.
REQ-018 SHALL advance rd_ptr by req_n on grant; pointers wrap modulo DEPTH.
REQ-019 SHALL update occupancy = occupancy + push - (grant ? req_n : 0) on simultaneous push and pop.
REQ-020 SHALL, when req_n = 0, assert no grant and leave rd_ptr unchanged.
REQ-021 SHALL give flush priority: on flush, rd_ptr, wr_ptr, occupancy go to 0, ssm_rd_gnt = 0 that cycle, and any push that cycle is discarded.
REQ-022 SHALL keep ssm_rd_gnt a subset of ssm_rd_en at all times; no combinational path from ssm_rd_en to in_rdy.

Reset
REQ-023 SHALL on rstn low asynchronously clear rd_ptr, wr_ptr, occupancy to 0; in_rdy = 1, ssm_rd_gnt = 0, ssm_data = 0 while in reset.
REQ-024 SHALL not require buffer storage to be reset; reset mid-operation discards all buffered words.

Configuration
REQ-025 SHALL support macro SSM_DISPATCH_STAT_EN: when defined, adds outputs stall_cnt (32b, increments each cycle req_n > 0 and no grant) and word_cnt (32b, increments by req_n on grant), both saturating, cleared by rstn and flush.
REQ-026 SHALL, without SSM_DISPATCH_STAT_EN, omit stall_cnt/word_cnt ports and logic entirely; dispatch behaviour identical.

Structure
REQ-027 SHALL place default NUM_SSM, WORD_W, DEPTH and the occupancy-width function in package ssm_dispatch_pkg.
REQ-028 SHALL implement prefix popcount of ssm_rd_en in sub-module ssm_prefix_cnt (outputs per-index offset and total req_n).

Verification
REQ-029 SHALL verify: reset, push words W0..W7, rd_en=4'b1111 -> gnt=4'b1111, SSM0..3 get W0..W3, occupancy 8->4.
REQ-030 SHALL verify: buffer holds W0..W3, rd_en=4'b1010 -> SSM1=W0, SSM3=W1, SSM0/2 data 0, occupancy 4->2.
REQ-031 SHALL verify: occupancy=2, rd_en=4'b0111 -> gnt=0, stall_cnt+1 (macro on), occupancy stays 2; next cycle with push and occupancy 3 -> grant.
REQ-032 SHALL verify: DEPTH=8, rd_ptr=6, rd_en=4'b1111 -> words from entries 6,7,0,1; rd_ptr=2 (wrap).
REQ-033 SHALL verify: occupancy=8 -> in_rdy=0, in_vld ignored; same cycle pop 2 -> occupancy 6, in_rdy=1 next cycle.
REQ-034 SHALL verify: flush with in_vld=1 and rd_en=4'b0001 -> gnt=0, occupancy 0, in_rdy=1 next cycle, pushed word discarded.

Source files
------------

// File: rtl/ssm_dispatch_pkg.sv
// Shared defaults and width helpers for the SSM word dispatcher.
package ssm_dispatch_pkg;

  localparam int SSM_NUM_DEF    = 4;
  localparam int SSM_WORD_W_DEF = 128;
  localparam int SSM_DEPTH_DEF  = 8;

  // Width able to hold a count of 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ssm_prefix_cnt.sv
// Exclusive prefix popcount of the parser request vector plus the total count.
module ssm_prefix_cnt #(
  parameter int NUM_SSM = 4,
  parameter int CNT_W   = 3
) (
  input  logic [NUM_SSM-1:0]            i_rd_en,
  output logic [NUM_SSM-1:0][CNT_W-1:0] o_offset,
  output logic [CNT_W-1:0]              o_total
);

  always_comb begin
    logic [CNT_W-1:0] acc;
    acc      = '0;
    o_offset = '0;
    for (int i = 0; i < NUM_SSM; i++) begin
      o_offset[i] = acc;
      acc         = acc + CNT_W'(i_rd_en[i]);
    end
    o_total = acc;
  end

endmodule

// File: rtl/ssm_word_dispatch.sv
// Circular word buffer feeding up to NUM_SSM substream parsers per cycle, all-or-nothing.
// Optional statistics counters enabled by defining SSM_DISPATCH_STAT_EN.
module ssm_word_dispatch
  import ssm_dispatch_pkg::*;
#(
  parameter int NUM_SSM = SSM_NUM_DEF,
  parameter int WORD_W  = SSM_WORD_W_DEF,
  parameter int DEPTH   = SSM_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_vld,
  input  logic [WORD_W-1:0]           in_data,
  output logic                        in_rdy,
  input  logic                        flush,
  input  logic [NUM_SSM-1:0]          ssm_rd_en,
  output logic [NUM_SSM-1:0]          ssm_rd_gnt,
  output logic [NUM_SSM*WORD_W-1:0]   ssm_data,
`ifdef SSM_DISPATCH_STAT_EN
  output logic [31:0]                 stall_cnt,
  output logic [31:0]                 word_cnt,
`endif
  output logic [occ_width(DEPTH)-1:0] occupancy
);

  localparam int OCC_W = occ_width(DEPTH);
  localparam int CNT_W = occ_width(NUM_SSM);
  localparam int PTR_W = ptr_width(DEPTH);

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] n);
    int s;
    s = int'(p) + int'(n);
    return PTR_W'(s % DEPTH);
  endfunction

  logic [WORD_W-1:0]            r_mem [DEPTH];
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [OCC_W-1:0]             r_occ;
  logic [NUM_SSM-1:0][CNT_W-1:0] w_offset;
  logic [CNT_W-1:0]             w_req_n;
  logic [OCC_W-1:0]             w_req_occ;
  logic                         w_push;
  logic                         w_grant;

  ssm_prefix_cnt #(
    .NUM_SSM (NUM_SSM),
    .CNT_W   (CNT_W)
  ) u_prefix (
    .i_rd_en  (ssm_rd_en),
    .o_offset (w_offset),
    .o_total  (w_req_n)
  );

  // in_rdy depends only on registered occupancy, never on the request vector.
  assign w_req_occ  = OCC_W'(w_req_n);
  assign in_rdy     = (r_occ < OCC_W'(DEPTH));
  assign w_push     = in_vld & in_rdy & ~flush;
  assign w_grant    = ~flush & (w_req_n != '0) & (r_occ >= w_req_occ);
  assign ssm_rd_gnt = w_grant ? ssm_rd_en : '0;
  assign occupancy  = r_occ;

  always_comb begin
    ssm_data = '0;
    for (int i = 0; i < NUM_SSM; i++) begin
      if (ssm_rd_gnt[i]) begin
        ssm_data[i*WORD_W +: WORD_W] = r_mem[ptr_add(r_rd_ptr, w_offset[i])];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_add(r_wr_ptr, CNT_W'(1));
      end
      if (w_grant) begin
        r_rd_ptr <= ptr_add(r_rd_ptr, w_req_n);
      end
      r_occ <= r_occ + OCC_W'(w_push) - (w_grant ? w_req_occ : '0);
    end
  end

  // Word storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

`ifdef SSM_DISPATCH_STAT_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  logic [31:0] r_stall_cnt;
  logic [31:0] r_word_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
      r_word_cnt  <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
      r_word_cnt  <= '0;
    end else begin
      if ((w_req_n != '0) && !w_grant) begin
        r_stall_cnt <= sat_add(r_stall_cnt, 32'd1);
      end
      if (w_grant) begin
        r_word_cnt <= sat_add(r_word_cnt, 32'(w_req_n));
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign word_cnt  = r_word_cnt;
`endif

endmodule

// File: tb/tb_ssm_word_dispatch.sv
// Scoreboard bench for ssm_word_dispatch: a queue model predicts grants, data and occupancy.
module tb_ssm_word_dispatch;
  import ssm_dispatch_pkg::*;

  localparam int NUM_SSM = 4;
  localparam int WORD_W  = 128;
  localparam int DEPTH   = 8;
  localparam int OCC_W   = occ_width(DEPTH);

  logic                      clk = 1'b0;
  logic                      rstn;
  logic                      in_vld;
  logic [WORD_W-1:0]         in_data;
  logic                      in_rdy;
  logic                      flush;
  logic [NUM_SSM-1:0]        ssm_rd_en;
  logic [NUM_SSM-1:0]        ssm_rd_gnt;
  logic [NUM_SSM*WORD_W-1:0] ssm_data;
  logic [OCC_W-1:0]          occupancy;
`ifdef SSM_DISPATCH_STAT_EN
  logic [31:0]               stall_cnt;
  logic [31:0]               word_cnt;
  int                        exp_stall = 0;
  int                        exp_word  = 0;
`endif

  int checks   = 0;
  int failures = 0;
  int word_seq = 0;
  logic [WORD_W-1:0] sb_q[$];

  always #5 clk = ~clk;

  ssm_word_dispatch #(
    .NUM_SSM (NUM_SSM),
    .WORD_W  (WORD_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_vld     (in_vld),
    .in_data    (in_data),
    .in_rdy     (in_rdy),
    .flush      (flush),
    .ssm_rd_en  (ssm_rd_en),
    .ssm_rd_gnt (ssm_rd_gnt),
    .ssm_data   (ssm_data),
`ifdef SSM_DISPATCH_STAT_EN
    .stall_cnt  (stall_cnt),
    .word_cnt   (word_cnt),
`endif
    .occupancy  (occupancy)
  );

  function automatic logic [WORD_W-1:0] mk_word(input int n);
    return {32'(32'hC0DE0000 + n), 32'(n * 3 + 1), ~32'(n), 32'(32'hA5A50000 | n)};
  endfunction

  function automatic int popc(input logic [NUM_SSM-1:0] v);
    int c = 0;
    for (int i = 0; i < NUM_SSM; i++) c += int'(v[i]);
    return c;
  endfunction

  // Expected grant and data for the inputs currently driven.
  task automatic model_expect(output logic [NUM_SSM-1:0] g, output logic [NUM_SSM*WORD_W-1:0] d);
    int rn = popc(ssm_rd_en);
    int k  = 0;
    g = '0;
    d = '0;
    if (!flush && rstn && rn > 0 && sb_q.size() >= rn) begin
      g = ssm_rd_en;
      for (int i = 0; i < NUM_SSM; i++) begin
        if (ssm_rd_en[i]) begin
          d[i*WORD_W +: WORD_W] = sb_q[k];
          k++;
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic [WORD_W-1:0] dat, input logic f,
                       input logic [NUM_SSM-1:0] en);
    in_vld = v; in_data = dat; flush = f; ssm_rd_en = en;
    #1;
  endtask

  // Advance one clock and update the scoreboard with what the edge should do.
  task automatic tick();
    logic [NUM_SSM-1:0]        g;
    logic [NUM_SSM*WORD_W-1:0] dd;
    logic [WORD_W-1:0]         d;
    bit push, f;
    int rn, rq;
    model_expect(g, dd);
    rn   = popc(g);
    rq   = popc(ssm_rd_en);
    push = in_vld && !flush && (sb_q.size() < DEPTH);
    d    = in_data;
    f    = flush;
    @(posedge clk);
    if (f) begin
      sb_q.delete();
`ifdef SSM_DISPATCH_STAT_EN
      exp_stall = 0; exp_word = 0;
`endif
    end else begin
      repeat (rn) void'(sb_q.pop_front());
      if (push) sb_q.push_back(d);
`ifdef SSM_DISPATCH_STAT_EN
      if (rq > 0 && rn == 0) exp_stall++;
      exp_word += rn;
`endif
    end
    #1;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, mk_word(word_seq), 1'b0, '0);
      word_seq++;
      tick();
    end
    drive(1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, '0);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    sb_q.delete();
`ifdef SSM_DISPATCH_STAT_EN
    exp_stall = 0; exp_word = 0;
`endif
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(1'b1, mk_word(999), 1'b0, 4'b1111);
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy: got %b want 1", in_rdy); end
    checks++; if (ssm_rd_gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b want 0000", ssm_rd_gnt); end
    checks++; if (ssm_data !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", ssm_data); end
    @(posedge clk); #1;
    checks++; if (occupancy !== '0) begin failures++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
`ifdef SSM_DISPATCH_STAT_EN
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
`endif
    drive(1'b0, '0, 1'b0, '0);
    rstn = 1'b1;
    sb_q.delete();
    #1;
  endtask

  task automatic test_full_grant(output int base);
    base = word_seq;
    push_words(8);
    checks++; if (occupancy !== OCC_W'(8)) begin failures++; $display("FAIL full_occ8: got %0d want 8", occupancy); end
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL full_rdy: got %b want 0", in_rdy); end
    drive(1'b0, '0, 1'b0, 4'b1111);
    checks++; if (ssm_rd_gnt !== 4'b1111) begin failures++; $display("FAIL full_gnt: got %b want 1111", ssm_rd_gnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ssm_data[i*WORD_W +: WORD_W] !== mk_word(base + i)) begin
        failures++;
        $display("FAIL full_data%0d: got %h want %h", i, ssm_data[i*WORD_W +: WORD_W], mk_word(base + i));
      end
    end
    tick();
    drive(1'b0, '0, 1'b0, '0);
    checks++; if (occupancy !== OCC_W'(4)) begin failures++; $display("FAIL full_occ4: got %0d want 4", occupancy); end
  endtask

  task automatic test_sparse(input int base);
    drive(1'b0, '0, 1'b0, 4'b1010);
    checks++; if (ssm_rd_gnt !== 4'b1010) begin failures++; $display("FAIL sparse_gnt: got %b want 1010", ssm_rd_gnt); end
    checks++; if (ssm_data[1*WORD_W +: WORD_W] !== mk_word(base + 4)) begin failures++; $display("FAIL sparse_ssm1: got %h want %h", ssm_data[1*WORD_W +: WORD_W], mk_word(base + 4)); end
    checks++; if (ssm_data[3*WORD_W +: WORD_W] !== mk_word(base + 5)) begin failures++; $display("FAIL sparse_ssm3: got %h want %h", ssm_data[3*WORD_W +: WORD_W], mk_word(base + 5)); end
    checks++; if (ssm_data[0*WORD_W +: WORD_W] !== '0 || ssm_data[2*WORD_W +: WORD_W] !== '0) begin failures++; $display("FAIL sparse_zero: got %h want zero slices 0/2", ssm_data); end
    tick();
    drive(1'b0, '0, 1'b0, '0);
    checks++; if (occupancy !== OCC_W'(2)) begin failures++; $display("FAIL sparse_occ: got %0d want 2", occupancy); end
  endtask

  task automatic test_stall(input int base);
    int w;
    drive(1'b0, '0, 1'b0, 4'b0111);
    checks++; if (ssm_rd_gnt !== 4'b0000) begin failures++; $display("FAIL stall_gnt: got %b want 0000", ssm_rd_gnt); end
    checks++; if (ssm_data !== '0) begin failures++; $display("FAIL stall_data: got %h want 0", ssm_data); end
    tick();
    checks++; if (occupancy !== OCC_W'(2)) begin failures++; $display("FAIL stall_occ: got %0d want 2", occupancy); end
`ifdef SSM_DISPATCH_STAT_EN
    checks++; if (stall_cnt !== 32'd1) begin failures++; $display("FAIL stall_cnt: got %0d want 1", stall_cnt); end
`endif
    w = word_seq; word_seq++;
    drive(1'b1, mk_word(w), 1'b0, 4'b0111);
    checks++; if (ssm_rd_gnt !== 4'b0000) begin failures++; $display("FAIL stall_push_gnt: got %b want 0000", ssm_rd_gnt); end
    tick();
    drive(1'b0, '0, 1'b0, 4'b0111);
    checks++; if (occupancy !== OCC_W'(3)) begin failures++; $display("FAIL stall_occ3: got %0d want 3", occupancy); end
    checks++; if (ssm_rd_gnt !== 4'b0111) begin failures++; $display("FAIL stall_release_gnt: got %b want 0111", ssm_rd_gnt); end
    checks++;
    if (ssm_data[0 +: 3*WORD_W] !== {mk_word(w), mk_word(base + 7), mk_word(base + 6)}) begin
      failures++;
      $display("FAIL stall_release_data: got %h", ssm_data[0 +: 3*WORD_W]);
    end
    tick();
    drive(1'b0, '0, 1'b0, '0);
    checks++; if (occupancy !== '0) begin failures++; $display("FAIL stall_occ0: got %0d want 0", occupancy); end
  endtask

  task automatic test_wrap();
    int b;
    do_reset();
    push_words(6);
    drive(1'b0, '0, 1'b0, 4'b1111); tick();
    drive(1'b0, '0, 1'b0, 4'b0011); tick();
    b = word_seq;
    push_words(4);
    drive(1'b0, '0, 1'b0, 4'b0000);
    checks++; if (ssm_rd_gnt !== 4'b0000) begin failures++; $display("FAIL noreq_gnt: got %b want 0000", ssm_rd_gnt); end
    tick();
    checks++; if (occupancy !== OCC_W'(4)) begin failures++; $display("FAIL noreq_occ: got %0d want 4", occupancy); end
    drive(1'b0, '0, 1'b0, 4'b1111);
    checks++; if (ssm_rd_gnt !== 4'b1111) begin failures++; $display("FAIL wrap_gnt: got %b want 1111", ssm_rd_gnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ssm_data[i*WORD_W +: WORD_W] !== mk_word(b + i)) begin
        failures++;
        $display("FAIL wrap_data%0d: got %h want %h", i, ssm_data[i*WORD_W +: WORD_W], mk_word(b + i));
      end
    end
    tick();
    b = word_seq;
    push_words(1);
    drive(1'b0, '0, 1'b0, 4'b0001);
    checks++; if (ssm_data[0 +: WORD_W] !== mk_word(b)) begin failures++; $display("FAIL wrap_ptr2: got %h want %h", ssm_data[0 +: WORD_W], mk_word(b)); end
    tick();
    drive(1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_full_pop();
    int b;
    b = word_seq;
    push_words(8);
    drive(1'b1, mk_word(5000), 1'b0, 4'b0011);
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL fullpop_rdy0: got %b want 0", in_rdy); end
    checks++; if (ssm_rd_gnt !== 4'b0011) begin failures++; $display("FAIL fullpop_gnt: got %b want 0011", ssm_rd_gnt); end
    checks++; if (ssm_data[WORD_W +: WORD_W] !== mk_word(b + 1)) begin failures++; $display("FAIL fullpop_data1: got %h want %h", ssm_data[WORD_W +: WORD_W], mk_word(b + 1)); end
    tick();
    drive(1'b0, '0, 1'b0, '0);
    checks++; if (occupancy !== OCC_W'(6)) begin failures++; $display("FAIL fullpop_occ: got %0d want 6", occupancy); end
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL fullpop_rdy1: got %b want 1", in_rdy); end
  endtask

  task automatic test_flush();
    drive(1'b1, mk_word(7777), 1'b1, 4'b0001);
    checks++; if (ssm_rd_gnt !== 4'b0000) begin failures++; $display("FAIL flush_gnt: got %b want 0000", ssm_rd_gnt); end
    checks++; if (ssm_data !== '0) begin failures++; $display("FAIL flush_data: got %h want 0", ssm_data); end
    tick();
    drive(1'b1, mk_word(7778), 1'b0, '0);
    checks++; if (occupancy !== '0) begin failures++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL flush_rdy: got %b want 1", in_rdy); end
`ifdef SSM_DISPATCH_STAT_EN
    checks++; if (word_cnt !== 32'd0 || stall_cnt !== 32'd0) begin failures++; $display("FAIL flush_stats: got %0d/%0d want 0/0", word_cnt, stall_cnt); end
`endif
    tick();
    drive(1'b0, '0, 1'b0, 4'b0001);
    checks++; if (ssm_data[0 +: WORD_W] !== mk_word(7778)) begin failures++; $display("FAIL flush_discard: got %h want %h", ssm_data[0 +: WORD_W], mk_word(7778)); end
    tick();
    drive(1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    int b;
    push_words(3);
    #3;
    rstn = 1'b0;
    #1;
    checks++; if (occupancy !== '0) begin failures++; $display("FAIL async_rst_occ: got %0d want 0", occupancy); end
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL async_rst_rdy: got %b want 1", in_rdy); end
    sb_q.delete();
`ifdef SSM_DISPATCH_STAT_EN
    exp_stall = 0; exp_word = 0;
`endif
    @(posedge clk); #1;
    rstn = 1'b1;
    b = word_seq;
    push_words(1);
    drive(1'b0, '0, 1'b0, 4'b0001);
    checks++; if (ssm_data[0 +: WORD_W] !== mk_word(b)) begin failures++; $display("FAIL rst_discard: got %h want %h", ssm_data[0 +: WORD_W], mk_word(b)); end
    tick();
    drive(1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    logic [NUM_SSM-1:0]        eg;
    logic [NUM_SSM*WORD_W-1:0] ed;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
            ($urandom_range(0, 31) == 0), 4'($urandom_range(0, 15)));
      model_expect(eg, ed);
      checks++; if (ssm_rd_gnt !== eg) begin failures++; $display("FAIL b2b_gnt c%0d: got %b want %b", c, ssm_rd_gnt, eg); end
      checks++; if (ssm_data !== ed) begin failures++; $display("FAIL b2b_data c%0d: got %h want %h", c, ssm_data, ed); end
      checks++; if (in_rdy !== (sb_q.size() < DEPTH)) begin failures++; $display("FAIL b2b_rdy c%0d: got %b want %b", c, in_rdy, sb_q.size() < DEPTH); end
      checks++; if (occupancy !== OCC_W'(sb_q.size())) begin failures++; $display("FAIL b2b_occ c%0d: got %0d want %0d", c, occupancy, sb_q.size()); end
`ifdef SSM_DISPATCH_STAT_EN
      checks++; if (stall_cnt !== 32'(exp_stall) || word_cnt !== 32'(exp_word)) begin failures++; $display("FAIL b2b_stats c%0d: got %0d/%0d want %0d/%0d", c, stall_cnt, word_cnt, exp_stall, exp_word); end
`endif
      tick();
    end
    drive(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    int base;
    rstn = 1'b0;
    in_vld = 1'b0; in_data = '0; flush = 1'b0; ssm_rd_en = '0;
    test_reset();
    test_full_grant(base);
    test_sparse(base);
    test_stall(base);
    test_wrap();
    test_full_pop();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
